// File: rtl/usr_shift_ctrl_if.sv
// Producer handshake and USR control/observe signals for usr_shift_ctrl.
// master = producer plus USR side, slave = the controller.
interface usr_shift_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             start_i;
    logic             dir_i;
    logic [WIDTH-1:0] data_i;
    logic             ready_o;
    logic             hold_i;
    logic [WIDTH-1:0] pout_i;
    logic [1:0]       sel_o;
    logic [WIDTH-1:0] pin_o;
    logic             slin_o;
    logic             srin_o;
    logic             ser_o;
    logic             ser_valid_o;
    logic             done_o;
    logic             busy_o;

    modport master (
        output start_i, dir_i, data_i, hold_i, pout_i,
        input  ready_o, sel_o, pin_o, slin_o, srin_o, ser_o, ser_valid_o, done_o, busy_o
    );

    modport slave (
        input  start_i, dir_i, data_i, hold_i, pout_i,
        output ready_o, sel_o, pin_o, slin_o, srin_o, ser_o, ser_valid_o, done_o, busy_o
    );
endinterface

// File: rtl/usr_shift_ctrl.sv
// Sequencer driving a universal shift register as a parallel-to-serial transmitter.
// Define USR_CTRL_ROTATE_EN to feed the outgoing bit back in so the USR keeps the word.
module usr_shift_ctrl #(
    parameter int WIDTH = 4
) (
    input logic             clk,
    input logic             rst,
    usr_shift_ctrl_if.slave bus
);
    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StLoad, StShift, StDone} state_e;

    state_e           r_state;
    state_e           w_state_next;
    logic [WIDTH-1:0] r_word;
    logic             r_dir;
    logic [CntW-1:0]  r_cnt;
    logic             w_accept;
    logic             w_shift_en;

    assign w_accept   = (r_state == StIdle) && bus.start_i;
    assign w_shift_en = (r_state == StShift) && !bus.hold_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
            r_word  <= '0;
            r_dir   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_word <= bus.data_i;
                r_dir  <= bus.dir_i;
                r_cnt  <= '0;
            end else if (w_shift_en && (r_cnt != CntLast)) begin
                // Saturate on the last bit so the count never passes WIDTH-1.
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_next    = r_state;
        bus.sel_o       = 2'b00;
        bus.ready_o     = 1'b0;
        bus.busy_o      = 1'b1;
        bus.done_o      = 1'b0;
        bus.ser_valid_o = 1'b0;
        bus.slin_o      = 1'b0;
        bus.srin_o      = 1'b0;
        unique case (r_state)
            StIdle: begin
                bus.ready_o = 1'b1;
                bus.busy_o  = 1'b0;
                if (bus.start_i) w_state_next = StLoad;
            end
            StLoad: begin
                bus.sel_o    = 2'b11;
                w_state_next = StShift;
            end
            StShift: begin
                if (!bus.hold_i) begin
                    bus.sel_o       = r_dir ? 2'b10 : 2'b01;
                    bus.ser_valid_o = 1'b1;
`ifdef USR_CTRL_ROTATE_EN
                    bus.slin_o = !r_dir && bus.pout_i[0];
                    bus.srin_o = r_dir && bus.pout_i[WIDTH-1];
`else
                    bus.slin_o = 1'b0;
                    bus.srin_o = 1'b0;
`endif
                    if (r_cnt == CntLast) w_state_next = StDone;
                end
            end
            StDone: begin
                bus.done_o   = 1'b1;
                w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    assign bus.pin_o = r_word;
    assign bus.ser_o = r_dir ? bus.pout_i[WIDTH-1] : bus.pout_i[0];
endmodule
